// File: rtl/uart_tx_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// uart_sched_pkg
// Shared definitions for the UART transmit scheduler:
//   - channel index constants (CH_GAMESTATE, CH_TARGET, CH_OPERATE, CH_NONE)
//   - scheduler FSM state encoding
//   - next_ch(): round-robin successor of a channel index
// No ports (package).
// -----------------------------------------------------------------------------
package uart_sched_pkg;

    localparam logic [1:0] CH_GAMESTATE = 2'd0;
    localparam logic [1:0] CH_TARGET    = 2'd1;
    localparam logic [1:0] CH_OPERATE   = 2'd2;
    localparam logic [1:0] CH_NONE      = 2'd3;

    localparam int unsigned NUM_CH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } state_t;

    // Round-robin successor: 0 -> 1 -> 2 -> 0. CH_NONE maps to channel 0.
    function automatic logic [1:0] next_ch(input logic [1:0] ch);
        case (ch)
            CH_GAMESTATE: return CH_TARGET;
            CH_TARGET:    return CH_OPERATE;
            default:      return CH_GAMESTATE;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
// Byte handshake between the scheduler and a UART transmitter.
//   tx_valid : scheduler -> transmitter, tx_data holds a byte on offer
//   tx_data  : scheduler -> transmitter, byte to transmit (8 bits)
//   tx_ready : transmitter -> scheduler, byte can be accepted
// Modports: master (scheduler side), slave (transmitter side).
// -----------------------------------------------------------------------------
interface uart_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_scheduler_arb.sv
// -----------------------------------------------------------------------------
// rr_arbiter3
// Purely combinational three-way round-robin arbiter. The search starts at the
// channel after last_grant and wraps; the first requesting channel wins.
//   req         in  3  request vector, bit i = channel i
//   last_grant  in  2  previously granted channel (CH_NONE treated as 2)
//   grant       out 2  granted channel (CH_NONE when nothing requested)
//   grant_valid out 1  a request was granted
// -----------------------------------------------------------------------------
module rr_arbiter3
    import uart_sched_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last_grant,
    output logic [1:0] grant,
    output logic       grant_valid
);

    logic [1:0] cand;

    always_comb begin
        grant       = CH_NONE;
        grant_valid = 1'b0;
        cand        = last_grant;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = next_ch(cand);
            if (!grant_valid && req[cand]) begin
                grant       = cand;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Watches three 8-bit source bytes and sends each one to a UART transmitter
// whenever it differs from the last byte accepted for that channel. Channels
// are served round-robin, one byte per SEND/GAP pass, with GAP_CYCLES idle
// cycles after every accepted byte. A 0x00 source is never sent.
//
// Optional feature (macro UART_TX_SCHED_REFRESH_EN): every REFRESH_CYCLES
// cycles all channels with a nonzero source are forced to resend.
//
// Parameters:
//   GAP_CYCLES     idle cycles after each accepted byte (1..255)
//   REFRESH_CYCLES refresh period, only used with UART_TX_SCHED_REFRESH_EN
// Ports:
//   uart_clk              in  1  sole clock, rising edge
//   rst                   in  1  asynchronous active-high reset
//   data_game_state       in  8  channel 0 source byte
//   data_target           in  8  channel 1 source byte
//   data_operate_verified in  8  channel 2 source byte
//   tx                    uart_tx_if.master (tx_valid, tx_data, tx_ready)
//   pending               out 3  per-channel send-pending flags
//   last_ch               out 2  channel of last accepted byte, 2'b11 = none
// -----------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned REFRESH_CYCLES = 1000000
) (
    input  logic        uart_clk,
    input  logic        rst,
    input  logic [7:0]  data_game_state,
    input  logic [7:0]  data_target,
    input  logic [7:0]  data_operate_verified,
    uart_tx_if.master   tx,
    output logic [2:0]  pending,
    output logic [1:0]  last_ch
);

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t     state;
    logic [7:0] src    [NUM_CH];
    logic [7:0] shadow [NUM_CH];
    logic [2:0] force_flags;
    logic [1:0] rr_ptr;
    logic [1:0] grant_q;
    logic [1:0] arb_grant;
    logic       arb_valid;
    logic       tx_valid_q;
    logic [7:0] tx_data_q;
    logic [7:0] gap_cnt;
    logic       accept;

    assign src[0] = data_game_state;
    assign src[1] = data_target;
    assign src[2] = data_operate_verified;

    // A zero source is never pending, even when refresh has forced the channel.
    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pending[i] = (src[i] != 8'h00) &&
                         ((src[i] != shadow[i]) || force_flags[i]);
        end
    end

    assign accept = (state == SEND) && tx_valid_q && tx.tx_ready;

    rr_arbiter3 u_arb (
        .req         (pending),
        .last_grant  (rr_ptr),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
            end
            rr_ptr     <= CH_OPERATE;
            grant_q    <= CH_GAMESTATE;
            last_ch    <= CH_NONE;
            gap_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pending) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    // The source may have returned to its shadow value since
                    // IDLE; with nothing left to grant, fall back to IDLE.
                    if (arb_valid) begin
                        tx_data_q  <= src[arb_grant];
                        grant_q    <= arb_grant;
                        rr_ptr     <= arb_grant;
                        tx_valid_q <= 1'b1;
                        state      <= SEND;
                    end else begin
                        state <= IDLE;
                    end
                end
                SEND: begin
                    if (tx.tx_ready) begin
                        shadow[grant_q] <= tx_data_q;
                        last_ch         <= grant_q;
                        tx_valid_q      <= 1'b0;
                        gap_cnt         <= '0;
                        state           <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_TX_SCHED_REFRESH_EN
    localparam logic [31:0] REFRESH_LAST = 32'(REFRESH_CYCLES - 1);

    logic [31:0] refresh_cnt;
    logic        refresh_wrap;

    assign refresh_wrap = (refresh_cnt == REFRESH_LAST);

    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
        end else if (refresh_wrap) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 32'd1;
        end
    end

    // Wrap is written last so a wrap coinciding with an acceptance keeps the
    // accepted channel's force bit set.
    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            force_flags <= '0;
        end else begin
            if (accept) begin
                force_flags[grant_q] <= 1'b0;
            end
            if (refresh_wrap) begin
                force_flags <= '1;
            end
        end
    end
`else
    assign force_flags = '0;

    // REFRESH_CYCLES has no effect without the refresh feature.
    logic unused_refresh;
    assign unused_refresh = ^{REFRESH_CYCLES, accept};
`endif

    assign tx.tx_valid = tx_valid_q;
    assign tx.tx_data  = tx_data_q;

endmodule
